axi4l_periph_slave: RTL and testbench
=====================================

Name: axi4l_periph_slave

Overview:
AXI4-Lite slave peripheral that sits directly downstream of the bench's AXI4-Lite interface and consumes all five channels. It holds a small register file that drives the LEDs, a 4-digit multiplexed seven-segment display and a maskable interrupt fed by EXT_IRQ_IN. Each channel handshake is completed with single-outstanding-transaction semantics.

Parameters:
ADDR_WIDTH, `ADDR_WIDTH, address bus width
DATA_WIDTH, `DATA_WIDTH, data bus width (32 required; WSTRB is 4 bits)
REFRESH_DIV, 50000, ACLK cycles each seven-segment digit is displayed
ID_VALUE, 32'h41584C31, constant returned by the ID register

Ports:
ACLK  in  1  clock; all logic on posedge
ARESET  in  1  synchronous, active-high reset
AWADDR  in  ADDR_WIDTH  write address
AWPROT  in  3  ignored
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  DATA_WIDTH  write data
WSTRB  in  4  byte enables
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  ADDR_WIDTH  read address
ARPROT  in  3  ignored
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  DATA_WIDTH  read data
RRESP  out  2  read response
RVALID  out  1  read data valid
RREADY  in  1  read data ready
EXT_IRQ_IN  in  1  asynchronous external interrupt
LED  out  4  LED_REG[3:0]
SEG_CATHODE  out  7  active-low segments, bit order {g,f,e,d,c,b,a}
SEG_ANODE  out  4  active-low one-hot digit select
IRQ_OUT  out  1  IRQ_EN[0] & IRQ_STATUS[0]

Behaviour:
- Register map: decode uses ADDR[7:2]; ADDR[1:0] and bits above 7 are ignored.
  - 0x00 LED_REG: RW, bits [3:0].
  - 0x04 SEG_DATA: RW, bits [15:0]; digit0 = [3:0].
  - 0x08 IRQ_EN: RW, bit [0].
  - 0x0C IRQ_STATUS: bit [0]; writing 1 clears it (W1C).
  - 0x10 SCRATCH: RW, 32 bits.
  - 0x14 ID: RO, returns ID_VALUE.
  - Unimplemented bits read 0.
- Response codes:
  - OKAY=2'b00 for accepted accesses.
  - SLVERR=2'b10 for offsets >=0x18 and for any write to ID.
  - SLVERR writes have no effect; SLVERR reads return RDATA=0.
- WSTRB: byte i is updated only when WSTRB[i]=1. WSTRB=0 still completes with OKAY and changes nothing.
- Reset (ARESET sampled high at a posedge) sets outputs to:
  - AWREADY, WREADY, ARREADY, BVALID, RVALID = 0.
  - BRESP, RRESP = 0; RDATA = 0; LED = 0; IRQ_OUT = 0.
  - SEG_ANODE = 4'b1110; SEG_CATHODE = 7'b1000000.
  - All registers and the refresh counter are cleared.
  - In-flight transactions are discarded, with no response.
- Write path:
  - AWREADY = !ARESET & !aw_held & !BVALID. WREADY is the same condition using w_held.
  - AW and W may arrive in either order or in the same cycle. Each is latched on its own handshake.
  - At the first edge where both are held (or handshaking), the register is written and BVALID rises with BRESP. AW and W handshaking in cycle N gives register update and BVALID in cycle N+1.
  - BVALID holds until BREADY. The held flags clear on the B handshake, and the next AW/W may then be accepted in the following cycle.
- Read path:
  - ARREADY = !ARESET & !RVALID.
  - An AR handshake in cycle N gives RVALID/RDATA/RRESP in cycle N+1, stable until RREADY.
  - If a read and a write commit in the same cycle to the same register, the read returns the pre-write value.
- Interrupt:
  - EXT_IRQ_IN passes through a 2-flop synchroniser, then a rising-edge detector.
  - IRQ_STATUS[0] sets 3 cycles after EXT_IRQ_IN rises.
  - If a set and a W1C clear occur in the same cycle, the set wins.
  - A held-high input does not re-set the bit after a clear.
- Seven-segment scanner:
  - Counter runs 0..REFRESH_DIV-1. On wrap, the digit index advances 0→1→2→3→0.
  - SEG_ANODE = ~(1<<idx). SEG_CATHODE = hex-to-7seg of the selected nibble (0–F, active-low).
  - Both outputs are registered and change together.

Decomposition:
- Package axi4l_periph_pkg holds:
  - register offset localparams;
  - RESP_OKAY and RESP_SLVERR;
  - the default ID_VALUE;
  - a hex-to-7seg function.
- Sub-module seg7_scanner(ACLK, ARESET, seg_data[15:0], SEG_CATHODE, SEG_ANODE), parameterised by REFRESH_DIV.

Test Plan:
- Reset check: after ARESET, all outputs match their reset values. One cycle after ARESET falls, AWREADY=WREADY=ARREADY=1.
- Write then read: AW 0x00 and W 0x0000000A with WSTRB=4'hF in the same cycle → BVALID next cycle with BRESP=00, LED=4'hA. Read 0x00 → RDATA=0x0000000A, RRESP=00.
- Strobes, with W arriving before AW: W 0xDEADBEEF (WSTRB=4'b0101) 3 cycles before AW 0x10 → SCRATCH=0x00AD00EF.
- Error responses: write 0x14 → BRESP=10, ID unchanged. Read 0x20 → RRESP=10, RDATA=0.
- Backpressure: BREADY and RREADY held low for 5 cycles → BVALID/RVALID, BRESP/RRESP and RDATA stay stable, and AWREADY/ARREADY stay 0 until the handshake completes.
- Interrupt: IRQ_EN=1, pulse EXT_IRQ_IN → IRQ_OUT=1 within 3 cycles. Write 1 to 0x0C → IRQ_OUT=0. With REFRESH_DIV=4 and SEG_DATA=0x1234, SEG_ANODE cycles 1110→1101→1011→0111 every 4 cycles, and cathode on digit0 = 7'b0011001 ("4").

Source files
------------

// File: rtl/axi4l_periph_pkg.sv
// Shared definitions for the AXI4-Lite peripheral slave: register offsets, response codes, helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package axi4l_periph_pkg;

  // Byte offsets of the register map; decode compares bits [7:2] only.
  localparam logic [7:0] OFF_LED     = 8'h00;
  localparam logic [7:0] OFF_SEG     = 8'h04;
  localparam logic [7:0] OFF_IRQ_EN  = 8'h08;
  localparam logic [7:0] OFF_IRQ_ST  = 8'h0C;
  localparam logic [7:0] OFF_SCRATCH = 8'h10;
  localparam logic [7:0] OFF_ID      = 8'h14;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'h41584C31;

  // Hex digit to active-low segments, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg7(input logic [3:0] nib);
    logic [6:0] seg;
    seg = 7'b1111111;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_scanner.sv
// Four-digit multiplexed seven-segment scanner; each digit is shown for REFRESH_DIV cycles.
// Latency: outputs registered, one cycle from seg_data to SEG_CATHODE.
// Backpressure: none, free-running.
module seg7_scanner
  import axi4l_periph_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [15:0] seg_data,
  output logic [6:0]  SEG_CATHODE,
  output logic [3:0]  SEG_ANODE
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [1:0]    idx_nxt;
  logic          wrap;
  logic [3:0]    nib;

  assign wrap    = (cnt == CW'(REFRESH_DIV - 1));
  assign idx_nxt = wrap ? idx + 2'd1 : idx;

  // Pick the nibble of the digit that will be shown after this edge.
  always_comb begin
    nib = seg_data[3:0];
    case (idx_nxt)
      2'd0: nib = seg_data[3:0];
      2'd1: nib = seg_data[7:4];
      2'd2: nib = seg_data[11:8];
      2'd3: nib = seg_data[15:12];
      default: nib = seg_data[3:0];
    endcase
  end

  // Refresh counter, digit index and registered anode/cathode updated together.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cnt         <= '0;
      idx         <= 2'd0;
      SEG_ANODE   <= 4'b1110;
      SEG_CATHODE <= 7'b1000000;
    end else begin
      cnt         <= wrap ? '0 : cnt + 1'b1;
      idx         <= idx_nxt;
      SEG_ANODE   <= ~(4'b0001 << idx_nxt);
      SEG_CATHODE <= hex_to_seg7(nib);
    end
  end

endmodule

// File: rtl/axi4l_periph_slave.sv
// AXI4-Lite register slave driving LEDs, a 7-seg display and a maskable external interrupt.
// Latency: B one cycle after both AW and W are held; R one cycle after AR handshake.
// Backpressure: single outstanding per direction; AW/W/AR ready drop while a response is pending.
module axi4l_periph_slave
  import axi4l_periph_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DATA_WIDTH  = 32,
  parameter int          REFRESH_DIV = 50000,
  parameter logic [31:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [2:0]            AWPROT,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [3:0]            WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [2:0]            ARPROT,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY,
  input  logic                  EXT_IRQ_IN,
  output logic [3:0]            LED,
  output logic [6:0]            SEG_CATHODE,
  output logic [3:0]            SEG_ANODE,
  output logic                  IRQ_OUT
);

  logic        aw_held, w_held;
  logic [5:0]  aw_idx_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic        aw_fire, w_fire, ar_fire;
  logic [5:0]  wr_idx, rd_idx;
  logic [31:0] wr_data, wr_cur, wr_merged, rd_word;
  logic [3:0]  wr_strb;
  logic        wr_commit, wr_ok, rd_ok;
  logic [3:0]  led_q;
  logic [15:0] seg_q;
  logic        irq_en_q, irq_st_q;
  logic [31:0] scratch_q;
  logic        ext_s1, ext_s2, ext_s3, irq_rise;
  logic        unused_ok;

  // Protection bits and undecoded address bits have no meaning here.
  assign unused_ok = ^{AWPROT, ARPROT, AWADDR[ADDR_WIDTH-1:8], AWADDR[1:0],
                       ARADDR[ADDR_WIDTH-1:8], ARADDR[1:0]};

  assign AWREADY = !ARESET && !aw_held && !BVALID;
  assign WREADY  = !ARESET && !w_held && !BVALID;
  assign ARREADY = !ARESET && !RVALID;
  assign aw_fire = AWVALID && AWREADY;
  assign w_fire  = WVALID && WREADY;
  assign ar_fire = ARVALID && ARREADY;

  // A channel handshaking this cycle is used directly so AW+W together commit next edge.
  assign wr_idx    = aw_held ? aw_idx_q : AWADDR[7:2];
  assign wr_data   = w_held ? w_data_q : WDATA[31:0];
  assign wr_strb   = w_held ? w_strb_q : WSTRB;
  assign wr_commit = (aw_held || aw_fire) && (w_held || w_fire) && !BVALID;
  assign wr_ok     = (wr_idx < OFF_ID[7:2]);
  assign rd_idx    = ARADDR[7:2];
  assign rd_ok     = (rd_idx <= OFF_ID[7:2]);

  // Current value of the write target, so strobes can merge into it.
  always_comb begin
    wr_cur = 32'h0;
    case (wr_idx)
      OFF_LED[7:2]:     wr_cur = {28'h0, led_q};
      OFF_SEG[7:2]:     wr_cur = {16'h0, seg_q};
      OFF_IRQ_EN[7:2]:  wr_cur = {31'h0, irq_en_q};
      OFF_SCRATCH[7:2]: wr_cur = scratch_q;
      default:          wr_cur = 32'h0;
    endcase
  end

  assign wr_merged = merge_bytes(wr_cur, wr_data, wr_strb);

  // Read mux over the pre-edge register values, so a same-cycle write is not visible.
  always_comb begin
    rd_word = 32'h0;
    case (rd_idx)
      OFF_LED[7:2]:     rd_word = {28'h0, led_q};
      OFF_SEG[7:2]:     rd_word = {16'h0, seg_q};
      OFF_IRQ_EN[7:2]:  rd_word = {31'h0, irq_en_q};
      OFF_IRQ_ST[7:2]:  rd_word = {31'h0, irq_st_q};
      OFF_SCRATCH[7:2]: rd_word = scratch_q;
      OFF_ID[7:2]:      rd_word = ID_VALUE;
      default:          rd_word = 32'h0;
    endcase
  end

  // AW/W capture, commit into B, and release of the held flags on the B handshake.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= 6'h0;
      w_data_q <= 32'h0;
      w_strb_q <= 4'h0;
      BVALID   <= 1'b0;
      BRESP    <= RESP_OKAY;
    end else begin
      if (BVALID && BREADY) begin
        BVALID  <= 1'b0;
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end else begin
        if (aw_fire) begin
          aw_held  <= 1'b1;
          aw_idx_q <= AWADDR[7:2];
        end
        if (w_fire) begin
          w_held   <= 1'b1;
          w_data_q <= WDATA[31:0];
          w_strb_q <= WSTRB;
        end
      end
      if (wr_commit) begin
        BVALID <= 1'b1;
        BRESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Writable registers; rejected writes leave everything untouched.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      led_q     <= 4'h0;
      seg_q     <= 16'h0;
      irq_en_q  <= 1'b0;
      scratch_q <= 32'h0;
    end else if (wr_commit && wr_ok) begin
      case (wr_idx)
        OFF_LED[7:2]:     led_q     <= wr_merged[3:0];
        OFF_SEG[7:2]:     seg_q     <= wr_merged[15:0];
        OFF_IRQ_EN[7:2]:  irq_en_q  <= wr_merged[0];
        OFF_SCRATCH[7:2]: scratch_q <= wr_merged;
        default:          ;
      endcase
    end
  end

  // Read response: launched on AR handshake, held stable until RREADY.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      RVALID <= 1'b0;
      RDATA  <= '0;
      RRESP  <= RESP_OKAY;
    end else if (ar_fire) begin
      RVALID <= 1'b1;
      RDATA  <= rd_ok ? DATA_WIDTH'(rd_word) : '0;
      RRESP  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (RVALID && RREADY) begin
      RVALID <= 1'b0;
    end
  end

  // Two-flop synchroniser plus a delayed copy for rising-edge detection.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ext_s1 <= 1'b0;
      ext_s2 <= 1'b0;
      ext_s3 <= 1'b0;
    end else begin
      ext_s1 <= EXT_IRQ_IN;
      ext_s2 <= ext_s1;
      ext_s3 <= ext_s2;
    end
  end

  assign irq_rise = ext_s2 && !ext_s3;

  // Sticky status: edge sets it, W1C clears it, a coincident set takes priority.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      irq_st_q <= 1'b0;
    end else if (irq_rise) begin
      irq_st_q <= 1'b1;
    end else if (wr_commit && wr_ok && (wr_idx == OFF_IRQ_ST[7:2]) && wr_strb[0] && wr_data[0]) begin
      irq_st_q <= 1'b0;
    end
  end

  assign LED     = led_q;
  assign IRQ_OUT = irq_en_q && irq_st_q;

  seg7_scanner #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_scan (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .seg_data   (seg_q),
    .SEG_CATHODE(SEG_CATHODE),
    .SEG_ANODE  (SEG_ANODE)
  );

endmodule

// File: tb/tb_axi4l_periph_slave.sv
// Bench for axi4l_periph_slave: directed AXI-Lite traffic against a register-map model.
// Latency: n/a.
// Backpressure: exercised by holding BREADY/RREADY low.
module tb_axi4l_periph_slave;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic [2:0]  ARPROT;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic        EXT_IRQ_IN;
  logic [3:0]  LED;
  logic [6:0]  SEG_CATHODE;
  logic [3:0]  SEG_ANODE;
  logic        IRQ_OUT;

  always #5 ACLK = ~ACLK;

  axi4l_periph_slave #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .REFRESH_DIV(4),
    .ID_VALUE   (32'h41584C31)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .EXT_IRQ_IN(EXT_IRQ_IN), .LED(LED), .SEG_CATHODE(SEG_CATHODE),
    .SEG_ANODE(SEG_ANODE), .IRQ_OUT(IRQ_OUT)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Register map model: word index 0..4 are storage, 5 is the constant ID.
  logic [31:0] m_reg [0:4];

  function automatic logic [31:0] reg_mask(input int i);
    case (i)
      0: return 32'h0000000F;
      1: return 32'h0000FFFF;
      2: return 32'h00000001;
      3: return 32'h00000001;
      default: return 32'hFFFFFFFF;
    endcase
  endfunction

  function automatic logic [33:0] model_read(input logic [31:0] a);
    int i;
    i = int'(a[7:2]);
    if (i == 5) return {2'b00, 32'h41584C31};
    if (i > 5) return {2'b10, 32'h0};
    return {2'b00, m_reg[i]};
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
    int i;
    logic [31:0] be;
    i = int'(a[7:2]);
    be = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    if (i > 4) begin
      resp = 2'b10;
    end else begin
      resp = 2'b00;
      if (i == 3) begin
        if (s[0] && d[0]) m_reg[3] = 32'h0;
      end else begin
        m_reg[i] = ((m_reg[i] & ~be) | (d & be)) & reg_mask(i);
      end
    end
  endtask

  // Compare process: predicts every B and R response and the LED outputs cycle by cycle.
  initial begin
    logic [31:0] q_aw [$];
    logic [35:0] q_w  [$];
    logic [33:0] q_r  [$];
    logic        b_act;
    logic        r_act;
    logic [1:0]  b_exp;
    logic [33:0] r_exp;
    logic [31:0] aw_a;
    logic [35:0] w_v;
    b_act = 1'b0;
    r_act = 1'b0;
    b_exp = 2'b00;
    r_exp = '0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        q_aw.delete(); q_w.delete(); q_r.delete();
        b_act = 1'b0; r_act = 1'b0;
        continue;
      end
      if (BVALID && !b_act) begin
        if (q_aw.size() == 0 || q_w.size() == 0) begin
          fail_now("b_without_request");
        end else begin
          aw_a = q_aw.pop_front();
          w_v  = q_w.pop_front();
          model_write(aw_a, w_v[31:0], w_v[35:32], b_exp);
          chk("bresp", {30'h0, BRESP}, {30'h0, b_exp});
        end
        b_act = 1'b1;
      end else if (BVALID) begin
        chk("bresp_stable", {30'h0, BRESP}, {30'h0, b_exp});
      end
      if (BVALID) begin
        chk("awready_while_b", {31'h0, AWREADY}, 32'h0);
        chk("wready_while_b", {31'h0, WREADY}, 32'h0);
        if (BREADY) b_act = 1'b0;
      end
      if (RVALID && !r_act) begin
        if (q_r.size() == 0) fail_now("r_without_request");
        else r_exp = q_r.pop_front();
        chk("rdata", RDATA, r_exp[31:0]);
        chk("rresp", {30'h0, RRESP}, {30'h0, r_exp[33:32]});
        r_act = 1'b1;
      end else if (RVALID) begin
        chk("rdata_stable", RDATA, r_exp[31:0]);
        chk("rresp_stable", {30'h0, RRESP}, {30'h0, r_exp[33:32]});
      end
      if (RVALID) begin
        chk("arready_while_r", {31'h0, ARREADY}, 32'h0);
        if (RREADY) r_act = 1'b0;
      end
      if (AWVALID && AWREADY) q_aw.push_back(AWADDR);
      if (WVALID && WREADY)   q_w.push_back({WSTRB, WDATA});
      if (ARVALID && ARREADY) q_r.push_back(model_read(ARADDR));
      chk("led", {28'h0, LED}, {28'h0, m_reg[0][3:0]});
    end
  end

  // lead > 0: W is presented that many cycles before AW; lead < 0: AW first.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, output logic [1:0] resp);
    int t;
    int aws;
    int ws;
    bit awd, wd, awh, wh;
    aws = (lead > 0) ? lead : 0;
    ws  = (lead < 0) ? -lead : 0;
    awd = 0; wd = 0; t = 0;
    AWADDR = a; WDATA = d; WSTRB = s;
    while (!(awd && wd) && t < 40) begin
      AWVALID = !awd && (t >= aws);
      WVALID  = !wd && (t >= ws);
      @(negedge ACLK);
      awh = AWVALID && AWREADY;
      wh  = WVALID && WREADY;
      @(posedge ACLK); #1;
      if (awh) awd = 1;
      if (wh) wd = 1;
      t++;
    end
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    if (!(awd && wd)) fail_now("aw_w_handshake");
    resp = 2'b11;
    t = 0;
    while (t < 40) begin
      @(negedge ACLK);
      if (BVALID && BREADY) begin
        resp = BRESP;
        @(posedge ACLK); #1;
        break;
      end
      t++;
    end
    if (t >= 40) fail_now("b_handshake");
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int t;
    bit arh;
    ARADDR = a;
    ARVALID = 1'b1;
    arh = 0; t = 0;
    while (!arh && t < 40) begin
      @(negedge ACLK);
      arh = ARVALID && ARREADY;
      @(posedge ACLK); #1;
      t++;
    end
    ARVALID = 1'b0;
    if (!arh) fail_now("ar_handshake");
    d = 32'hFFFFFFFF; resp = 2'b11;
    t = 0;
    while (t < 40) begin
      @(negedge ACLK);
      if (RVALID && RREADY) begin
        d = RDATA; resp = RRESP;
        @(posedge ACLK); #1;
        break;
      end
      t++;
    end
    if (t >= 40) fail_now("r_handshake");
  endtask

  initial begin
    logic [1:0]  br;
    logic [1:0]  rr;
    logic [31:0] rd;
    logic [3:0]  prev_an;
    logic [6:0]  seg_lut [0:3];
    int          bp_cnt;
    int          t;
    bit          synced;

    for (int i = 0; i < 5; i++) m_reg[i] = 32'h0;
    ARESET = 1'b1;
    AWADDR = '0; AWPROT = 3'b000; AWVALID = 1'b0;
    WDATA = '0; WSTRB = 4'h0; WVALID = 1'b0; BREADY = 1'b1;
    ARADDR = '0; ARPROT = 3'b000; ARVALID = 1'b0; RREADY = 1'b1;
    EXT_IRQ_IN = 1'b0;

    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_awready", {31'h0, AWREADY}, 32'h0);
    chk("rst_wready", {31'h0, WREADY}, 32'h0);
    chk("rst_arready", {31'h0, ARREADY}, 32'h0);
    chk("rst_bvalid", {31'h0, BVALID}, 32'h0);
    chk("rst_rvalid", {31'h0, RVALID}, 32'h0);
    chk("rst_resps", {28'h0, BRESP, RRESP}, 32'h0);
    chk("rst_rdata", RDATA, 32'h0);
    chk("rst_led", {28'h0, LED}, 32'h0);
    chk("rst_irq", {31'h0, IRQ_OUT}, 32'h0);
    chk("rst_anode", {28'h0, SEG_ANODE}, 32'h0000000E);
    chk("rst_cathode", {25'h0, SEG_CATHODE}, 32'h00000040);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("post_rst_ready", {29'h0, AWREADY, WREADY, ARREADY}, 32'h00000007);
    @(posedge ACLK); #1;

    // Basic write/read to LED.
    axi_write(32'h00, 32'h0000000A, 4'hF, 0, br);
    chk("led_bresp", {30'h0, br}, 32'h0);
    chk("led_value", {28'h0, LED}, 32'h0000000A);
    axi_read(32'h00, rd, rr);
    chk("led_read", rd, 32'h0000000A);
    chk("led_rresp", {30'h0, rr}, 32'h0);

    // Strobed write with W three cycles ahead of AW.
    axi_write(32'h10, 32'hDEADBEEF, 4'b0101, 3, br);
    axi_read(32'h10, rd, rr);
    chk("scratch_strobe", rd, 32'h00AD00EF);

    // AW before W, plus zero strobe to LED.
    axi_write(32'h10, 32'h11223344, 4'b1010, -2, br);
    axi_read(32'h10, rd, rr);
    chk("scratch_strobe2", rd, 32'h11AD33EF);
    axi_write(32'h00, 32'h00000005, 4'h0, 0, br);
    chk("strb0_bresp", {30'h0, br}, 32'h0);
    chk("strb0_led", {28'h0, LED}, 32'h0000000A);

    // Errors: ID is read-only, offsets from 0x18 up are unmapped.
    axi_write(32'h14, 32'h12345678, 4'hF, 0, br);
    chk("id_write_bresp", {30'h0, br}, 32'h00000002);
    axi_read(32'h14, rd, rr);
    chk("id_read", rd, 32'h41584C31);
    axi_read(32'h20, rd, rr);
    chk("bad_rresp", {30'h0, rr}, 32'h00000002);
    chk("bad_rdata", rd, 32'h0);
    axi_read(32'h18, rd, rr);
    chk("edge_rresp", {30'h0, rr}, 32'h00000002);
    axi_write(32'h1C, 32'hFFFFFFFF, 4'hF, 0, br);
    chk("bad_wr_bresp", {30'h0, br}, 32'h00000002);

    // Upper and low address bits are not decoded: 0x107 aliases 0x04.
    axi_write(32'h00000107, 32'h0000BEEF, 4'h3, 0, br);
    axi_read(32'h04, rd, rr);
    chk("alias_seg", rd, 32'h0000BEEF);

    // Write backpressure: BREADY low while IRQ_EN is set.
    BREADY = 1'b0;
    bp_cnt = 0;
    fork
      axi_write(32'h08, 32'h00000001, 4'hF, 0, br);
      begin
        repeat (6) begin
          @(negedge ACLK);
          if (BVALID) bp_cnt++;
        end
        @(posedge ACLK); #1;
        BREADY = 1'b1;
      end
    join
    chk("b_backpressure_cycles", bp_cnt, 5);

    // Read backpressure: RREADY low.
    RREADY = 1'b0;
    bp_cnt = 0;
    fork
      axi_read(32'h10, rd, rr);
      begin
        repeat (6) begin
          @(negedge ACLK);
          if (RVALID) bp_cnt++;
        end
        @(posedge ACLK); #1;
        RREADY = 1'b1;
      end
    join
    chk("r_backpressure_cycles", bp_cnt, 5);
    chk("r_backpressure_data", rd, 32'h11AD33EF);

    // Interrupt pulse: status visible on the third edge after the rise.
    EXT_IRQ_IN = 1'b1;
    @(posedge ACLK); #1;
    EXT_IRQ_IN = 1'b0;
    @(negedge ACLK);
    chk("irq_edge1", {31'h0, IRQ_OUT}, 32'h0);
    @(negedge ACLK);
    chk("irq_edge2", {31'h0, IRQ_OUT}, 32'h0);
    @(negedge ACLK);
    chk("irq_edge3", {31'h0, IRQ_OUT}, 32'h1);
    @(posedge ACLK); #1;
    m_reg[3] = 32'h1;
    axi_read(32'h0C, rd, rr);
    chk("irq_status_read", rd, 32'h1);
    axi_write(32'h0C, 32'h00000001, 4'hF, 0, br);
    chk("irq_w1c", {31'h0, IRQ_OUT}, 32'h0);

    // Held-high input sets once only.
    EXT_IRQ_IN = 1'b1;
    repeat (5) @(posedge ACLK);
    #1;
    chk("irq_held_set", {31'h0, IRQ_OUT}, 32'h1);
    m_reg[3] = 32'h1;
    axi_write(32'h0C, 32'h00000001, 4'h1, 0, br);
    repeat (6) @(posedge ACLK);
    #1;
    chk("irq_held_no_reset", {31'h0, IRQ_OUT}, 32'h0);
    axi_read(32'h0C, rd, rr);
    chk("irq_held_status", rd, 32'h0);
    EXT_IRQ_IN = 1'b0;
    repeat (4) @(posedge ACLK);
    #1;

    // Scanner with REFRESH_DIV=4 and SEG_DATA=0x1234.
    axi_write(32'h04, 32'h00001234, 4'hF, 0, br);
    seg_lut[0] = 7'b0011001;
    seg_lut[1] = 7'b0110000;
    seg_lut[2] = 7'b0100100;
    seg_lut[3] = 7'b1111001;
    @(negedge ACLK);
    prev_an = SEG_ANODE;
    synced = 0;
    t = 0;
    while (!synced && t < 40) begin
      @(negedge ACLK);
      if (SEG_ANODE == 4'b1110 && prev_an != 4'b1110) synced = 1;
      else prev_an = SEG_ANODE;
      t++;
    end
    if (!synced) fail_now("scan_sync");
    for (int step = 0; step < 8; step++) begin
      for (int c = 0; c < 4; c++) begin
        chk("scan_anode", {28'h0, SEG_ANODE}, {28'h0, ~(4'b0001 << (step % 4))});
        chk("scan_cathode", {25'h0, SEG_CATHODE}, {25'h0, seg_lut[step % 4]});
        @(negedge ACLK);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
